instr_fetch: RTL and testbench

Fetch stage of the RISC-V core. Holds the PC, issues word reads to instruction memory over a request/response handshake, and presents one instruction at a time to decode. The instr[31:7] field feeds the immediate extender and the decoder. The redirect input accepts the branch/jump target (pc + imm_ext) computed downstream and flushes any in-flight or held fetch.

---
 rtl/instr_fetch_pkg.sv | 17 +
 rtl/instr_fetch_pc_reg.sv | 38 +++
 rtl/instr_fetch.sv | 143 ++++++++++++++
 tb/tb_instr_fetch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared fetch-stage types and constants
package instr_fetch_pkg;

    // Five states need three bits.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// rtl/instr_fetch_pc_reg.sv - program counter with load / increment / hold select
module instr_fetch_pc_reg
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] target,
    input  logic        inc,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Load wins over increment; callers only load word-aligned targets.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = target;
        end else if (inc) begin
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, single-outstanding imem request, decode hold
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        misalign_err
);

    fetch_state_e state_q, state_d;
    logic         kill_q, kill_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         misalign_q, misalign_d;
    logic         pc_load;
    logic         pc_inc;
    logic [31:0]  pc;
    logic         redir_ok;
    logic         redir_bad;

    assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);

    instr_fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (pc_load),
        .target (redirect_target),
        .inc    (pc_inc),
        .pc     (pc)
    );

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        misalign_d = misalign_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (redir_bad) begin
                    misalign_d = 1'b1;
                    state_d    = S_HALT;
                end else if (redir_ok) begin
                    pc_load = 1'b1;
                    if (imem_req_ready) begin
                        // Request already left with the old address; its data must be dropped.
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redir_bad) begin
                    misalign_d = 1'b1;
                    state_d    = S_HALT;
                end else if (redir_ok) begin
                    pc_load = 1'b1;
                    if (imem_rsp_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d    = imem_rsp_data;
                        instr_pc_d = pc;
                        pc_inc     = 1'b1;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redir_bad) begin
                    misalign_d = 1'b1;
                    state_d    = S_HALT;
                end else if (redir_ok) begin
                    pc_load = 1'b1;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    state_d = S_REQ;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            kill_q     <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign instr_valid    = (state_q == S_HOLD);
    assign imem_addr      = pc;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch (RESET_PC=0 and RESET_PC=FFFF_FFFC)
module tb_instr_fetch;

    logic        clk;
    logic        rst_n          [2];
    logic        req_valid      [2];
    logic        req_ready      [2];
    logic [31:0] addr           [2];
    logic        rsp_valid      [2];
    logic [31:0] rsp_data       [2];
    logic        ivalid         [2];
    logic        iready         [2];
    logic [31:0] instr_w        [2];
    logic [31:0] ipc            [2];
    logic        redir_valid    [2];
    logic [31:0] redir_target   [2];
    logic        misalign       [2];

    int          rsp_delay      [2];
    logic        pend           [2];
    int          cnt            [2];
    logic [31:0] paddr          [2];

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] XORV = 32'hA5A5_0000;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .imem_req_valid(req_valid[0]), .imem_req_ready(req_ready[0]), .imem_addr(addr[0]),
        .imem_rsp_valid(rsp_valid[0]), .imem_rsp_data(rsp_data[0]),
        .instr_valid(ivalid[0]), .instr_ready(iready[0]), .instr(instr_w[0]), .instr_pc(ipc[0]),
        .redirect_valid(redir_valid[0]), .redirect_target(redir_target[0]),
        .misalign_err(misalign[0])
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .imem_req_valid(req_valid[1]), .imem_req_ready(req_ready[1]), .imem_addr(addr[1]),
        .imem_rsp_valid(rsp_valid[1]), .imem_rsp_data(rsp_data[1]),
        .instr_valid(ivalid[1]), .instr_ready(iready[1]), .instr(instr_w[1]), .instr_pc(ipc[1]),
        .redirect_valid(redir_valid[1]), .redirect_target(redir_target[1]),
        .misalign_err(misalign[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: responds rsp_delay cycles after the one-cycle minimum, data = addr ^ XORV.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            rsp_valid[i] = 1'b0;
            if (!rst_n[i]) begin
                pend[i] = 1'b0;
            end else begin
                if (pend[i]) begin
                    if (cnt[i] == 0) begin
                        rsp_valid[i] = 1'b1;
                        rsp_data[i]  = paddr[i] ^ XORV;
                        pend[i]      = 1'b0;
                    end else begin
                        cnt[i] = cnt[i] - 1;
                    end
                end
                if (req_valid[i] && req_ready[i]) begin
                    pend[i]  = 1'b1;
                    paddr[i] = addr[i];
                    cnt[i]   = rsp_delay[i];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i]        = 1'b0;
            req_ready[i]    = 1'b1;
            iready[i]       = 1'b1;
            redir_valid[i]  = 1'b0;
            redir_target[i] = 32'h0;
            rsp_delay[i]    = 0;
            pend[i]         = 1'b0;
            cnt[i]          = 0;
            paddr[i]        = 32'h0;
            rsp_valid[i]    = 1'b0;
            rsp_data[i]     = 32'h0;
        end
        repeat (3) step();

        // Reset values
        chk("rst_req_valid", {31'b0, req_valid[0]}, 32'd0);
        chk("rst_instr_valid", {31'b0, ivalid[0]}, 32'd0);
        chk("rst_instr", instr_w[0], 32'h0000_0013);
        chk("rst_instr_pc", ipc[0], 32'h0);
        chk("rst_addr", addr[0], 32'h0);
        chk("rst_misalign", {31'b0, misalign[0]}, 32'd0);

        // Sequential fetch with zero-wait memory: 0, 4, 8
        rst_n[0] = 1'b1;
        step();
        chk("first_req_valid", {31'b0, req_valid[0]}, 32'd1);
        chk("first_req_addr", addr[0], 32'h0);
        step();
        chk("wait_no_req", {31'b0, req_valid[0]}, 32'd0);
        step();
        chk("f0_valid", {31'b0, ivalid[0]}, 32'd1);
        chk("f0_pc", ipc[0], 32'h0);
        chk("f0_instr", instr_w[0], 32'h0 ^ XORV);
        repeat (3) step();
        chk("f1_valid", {31'b0, ivalid[0]}, 32'd1);
        chk("f1_pc", ipc[0], 32'h4);
        chk("f1_instr", instr_w[0], 32'h4 ^ XORV);
        repeat (3) step();
        chk("f2_valid", {31'b0, ivalid[0]}, 32'd1);
        chk("f2_pc", ipc[0], 32'h8);
        chk("f2_instr", instr_w[0], 32'h8 ^ XORV);

        // Decode stall for 5 cycles
        iready[0]    = 1'b0;
        rsp_delay[0] = 3;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_valid", {31'b0, ivalid[0]}, 32'd1);
            chk("stall_pc", ipc[0], 32'h8);
            chk("stall_instr", instr_w[0], 32'h8 ^ XORV);
            chk("stall_no_req", {31'b0, req_valid[0]}, 32'd0);
        end
        iready[0] = 1'b1;
        step();
        chk("resume_req_valid", {31'b0, req_valid[0]}, 32'd1);
        chk("resume_req_addr", addr[0], 32'hC);

        // Redirect while waiting on a slow response
        step();
        chk("slow_in_wait", {31'b0, req_valid[0]}, 32'd0);
        redir_valid[0]  = 1'b1;
        redir_target[0] = 32'h100;
        step();
        redir_valid[0] = 1'b0;
        rsp_delay[0]   = 0;
        chk("kill_no_instr_a", {31'b0, ivalid[0]}, 32'd0);
        step();
        chk("kill_no_instr_b", {31'b0, ivalid[0]}, 32'd0);
        step();
        chk("kill_no_instr_c", {31'b0, ivalid[0]}, 32'd0);
        chk("kill_no_req", {31'b0, req_valid[0]}, 32'd0);
        step();
        chk("kill_no_instr_d", {31'b0, ivalid[0]}, 32'd0);
        chk("redir_req_valid", {31'b0, req_valid[0]}, 32'd1);
        chk("redir_req_addr", addr[0], 32'h100);
        repeat (2) step();
        chk("f100_valid", {31'b0, ivalid[0]}, 32'd1);
        chk("f100_pc", ipc[0], 32'h100);
        chk("f100_instr", instr_w[0], 32'h100 ^ XORV);

        // Redirect in HOLD with instr_ready high: target beats pc+4
        redir_valid[0]  = 1'b1;
        redir_target[0] = 32'h40;
        step();
        redir_valid[0] = 1'b0;
        chk("hold_redir_req", {31'b0, req_valid[0]}, 32'd1);
        chk("hold_redir_addr", addr[0], 32'h40);
        chk("hold_redir_drop", {31'b0, ivalid[0]}, 32'd0);
        repeat (2) step();
        chk("f40_pc", ipc[0], 32'h40);
        chk("f40_instr", instr_w[0], 32'h40 ^ XORV);

        // Misaligned redirect halts the stage
        redir_valid[0]  = 1'b1;
        redir_target[0] = 32'h102;
        step();
        redir_valid[0] = 1'b0;
        chk("mis_err", {31'b0, misalign[0]}, 32'd1);
        chk("mis_no_instr", {31'b0, ivalid[0]}, 32'd0);
        chk("mis_pc_kept", addr[0], 32'h44);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("halt_no_req", {31'b0, req_valid[0]}, 32'd0);
            chk("halt_err_sticky", {31'b0, misalign[0]}, 32'd1);
        end
        rst_n[0] = 1'b0;
        #1;
        chk("halt_rst_err", {31'b0, misalign[0]}, 32'd0);
        chk("halt_rst_addr", addr[0], 32'h0);
        chk("halt_rst_req", {31'b0, req_valid[0]}, 32'd0);

        // Wrap from FFFF_FFFC, then reset while waiting
        step();
        rst_n[1] = 1'b1;
        step();
        chk("wrap_req0_addr", addr[1], 32'hFFFF_FFFC);
        chk("wrap_req0_valid", {31'b0, req_valid[1]}, 32'd1);
        repeat (2) step();
        chk("wrap_f0_pc", ipc[1], 32'hFFFF_FFFC);
        chk("wrap_f0_instr", instr_w[1], 32'hFFFF_FFFC ^ XORV);
        step();
        chk("wrap_req1_valid", {31'b0, req_valid[1]}, 32'd1);
        chk("wrap_req1_addr", addr[1], 32'h0);
        step();
        chk("wrap_in_wait", {31'b0, req_valid[1]}, 32'd0);
        rst_n[1] = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, req_valid[1]}, 32'd0);
        chk("mid_rst_ivalid", {31'b0, ivalid[1]}, 32'd0);
        chk("mid_rst_instr", instr_w[1], 32'h0000_0013);
        chk("mid_rst_pc", ipc[1], 32'hFFFF_FFFC);
        chk("mid_rst_addr", addr[1], 32'hFFFF_FFFC);
        chk("mid_rst_err", {31'b0, misalign[1]}, 32'd0);
        step();
        rst_n[1] = 1'b1;
        step();
        chk("post_rst_req", {31'b0, req_valid[1]}, 32'd1);
        chk("post_rst_addr", addr[1], 32'hFFFF_FFFC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
